// File: rtl/washing_mach_plant_if.sv
// Actuator/sensor bundle between the washing machine controller and its plant model.
//   master : controller side, drives the actuator commands and reads the sensors
//   slave  : plant side, reads the commands and drives the sensors
// Command signals : door_lock, fill_valve_on, drain_valve_on, motor_on, soap_wash, water_wash
// Sensor signals  : filled, drained, detergent_added, cycle_timeout, spin_timeout, level
// Optional        : fault (only when WASH_PLANT_FAULT_CHECK_EN is defined)
interface washing_mach_plant_if #(
  parameter int unsigned LVL_W = 8
);
  logic             door_lock;
  logic             fill_valve_on;
  logic             drain_valve_on;
  logic             motor_on;
  logic             soap_wash;
  logic             water_wash;
  logic             filled;
  logic             drained;
  logic             detergent_added;
  logic             cycle_timeout;
  logic             spin_timeout;
  logic [LVL_W-1:0] level;
`ifdef WASH_PLANT_FAULT_CHECK_EN
  logic             fault;
`endif

  modport master (
    output door_lock, fill_valve_on, drain_valve_on, motor_on, soap_wash, water_wash,
    input  filled, drained, detergent_added, cycle_timeout, spin_timeout, level
`ifdef WASH_PLANT_FAULT_CHECK_EN
    , input fault
`endif
  );

  modport slave (
    input  door_lock, fill_valve_on, drain_valve_on, motor_on, soap_wash, water_wash,
    output filled, drained, detergent_added, cycle_timeout, spin_timeout, level
`ifdef WASH_PLANT_FAULT_CHECK_EN
    , output fault
`endif
  );
endinterface

// File: rtl/washing_mach_plant.sv
// Plant/sensor model for the washing machine controller. Integrates the valve commands into a
// saturating water level, doses detergent after the drum has been full in the soap phase for
// DET_DELAY clocks, and times wash and spin activity.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   plant  : washing_mach_plant_if.slave (commands in, sensors out)
// Build option: WASH_PLANT_FAULT_CHECK_EN adds a sticky fault sensor that flags simultaneous
//   fill/drain, motor running with the door unlocked, and filling at full level.
module washing_mach_plant #(
  parameter int unsigned LVL_W       = 8,
  parameter int unsigned FULL_LEVEL  = 200,
  parameter int unsigned FILL_RATE   = 4,
  parameter int unsigned DRAIN_RATE  = 8,
  parameter int unsigned DET_DELAY   = 3,
  parameter int unsigned WASH_CYCLES = 50,
  parameter int unsigned SPIN_CYCLES = 30
) (
  input logic                  clk,
  input logic                  reset,
  washing_mach_plant_if.slave  plant
);

  localparam int unsigned DetW  = $clog2(DET_DELAY + 1);
  localparam int unsigned CycW  = $clog2(WASH_CYCLES + 1);
  localparam int unsigned SpinW = $clog2(SPIN_CYCLES + 1);

  // Level arithmetic is done one bit wider so the fill sum never wraps before saturation.
  localparam logic [LVL_W:0]   FillInc  = (LVL_W + 1)'(FILL_RATE);
  localparam logic [LVL_W:0]   DrainDec = (LVL_W + 1)'(DRAIN_RATE);
  localparam logic [LVL_W:0]   FullExt  = (LVL_W + 1)'(FULL_LEVEL);
  localparam logic [LVL_W-1:0] FullLvl  = LVL_W'(FULL_LEVEL);

  localparam logic [DetW-1:0]  DetMax  = DetW'(DET_DELAY - 1);
  localparam logic [CycW-1:0]  CycMax  = CycW'(WASH_CYCLES - 1);
  localparam logic [SpinW-1:0] SpinMax = SpinW'(SPIN_CYCLES - 1);

  logic [LVL_W-1:0] level_q, level_d;
  logic [DetW-1:0]  det_cnt_q, det_cnt_d;
  logic [CycW-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [SpinW-1:0] spin_cnt_q, spin_cnt_d;
  logic             det_q, det_d;
  logic             cyc_to_q, cyc_to_d;
  logic             spin_to_q, spin_to_d;

  logic             filled;
  logic             det_cond;
  logic             wash_act;
  logic             spin_act;
  logic [LVL_W:0]   level_ext;
  logic [LVL_W:0]   fill_sum;

  assign filled    = (level_q >= FullLvl);
  assign det_cond  = plant.soap_wash & filled;
  // drain_valve_on separates the two phases, so wash_act and spin_act never overlap.
  assign wash_act  = plant.motor_on & (plant.soap_wash | plant.water_wash) & ~plant.drain_valve_on;
  assign spin_act  = plant.motor_on & plant.drain_valve_on;
  assign level_ext = {1'b0, level_q};
  assign fill_sum  = level_ext + FillInc;

  always_comb begin
    level_d = level_q;
    if (plant.fill_valve_on && !plant.drain_valve_on) begin
      level_d = (fill_sum >= FullExt) ? FullLvl : LVL_W'(fill_sum);
    end else if (plant.drain_valve_on && !plant.fill_valve_on) begin
      level_d = (level_ext <= DrainDec) ? '0 : LVL_W'(level_ext - DrainDec);
    end
  end

  // Each counter saturates at its terminal value; the flag is set on the clock after the
  // terminal value is reached and drops with the qualifying condition (no pause/resume).
  always_comb begin
    det_cnt_d = '0;
    det_d     = 1'b0;
    if (det_cond) begin
      det_cnt_d = (det_cnt_q == DetMax) ? det_cnt_q : det_cnt_q + DetW'(1);
      det_d     = det_q | (det_cnt_q == DetMax);
    end
  end

  always_comb begin
    cyc_cnt_d = '0;
    cyc_to_d  = 1'b0;
    if (wash_act) begin
      cyc_cnt_d = (cyc_cnt_q == CycMax) ? cyc_cnt_q : cyc_cnt_q + CycW'(1);
      cyc_to_d  = cyc_to_q | (cyc_cnt_q == CycMax);
    end
  end

  always_comb begin
    spin_cnt_d = '0;
    spin_to_d  = 1'b0;
    if (spin_act) begin
      spin_cnt_d = (spin_cnt_q == SpinMax) ? spin_cnt_q : spin_cnt_q + SpinW'(1);
      spin_to_d  = spin_to_q | (spin_cnt_q == SpinMax);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q    <= '0;
      det_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      spin_cnt_q <= '0;
      det_q      <= 1'b0;
      cyc_to_q   <= 1'b0;
      spin_to_q  <= 1'b0;
    end else begin
      level_q    <= level_d;
      det_cnt_q  <= det_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      spin_cnt_q <= spin_cnt_d;
      det_q      <= det_d;
      cyc_to_q   <= cyc_to_d;
      spin_to_q  <= spin_to_d;
    end
  end

  assign plant.level           = level_q;
  assign plant.filled          = filled;
  assign plant.drained         = (level_q == '0);
  assign plant.detergent_added = det_q;
  assign plant.cycle_timeout   = cyc_to_q;
  assign plant.spin_timeout    = spin_to_q;

`ifdef WASH_PLANT_FAULT_CHECK_EN
  logic fault_q;
  logic fault_set;

  assign fault_set = (plant.fill_valve_on & plant.drain_valve_on) |
                     (plant.motor_on & ~plant.door_lock) |
                     (plant.fill_valve_on & (level_q == FullLvl));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end

  assign plant.fault = fault_q;
`endif

endmodule
